// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the single-cycle ROM and
// holds the fetched word in an IF/ID register with a valid/ready handshake.
`timescale 1ns/1ps
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        busy,
  output logic        done,
  output logic [15:0] fetch_cnt
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic [15:0] r_fetch_cnt;

  state_t      w_nxt_state;
  logic [31:0] w_nxt_pc;
  logic        w_nxt_valid;
  logic [31:0] w_nxt_inst;
  logic [31:0] w_nxt_if_pc;
  logic [15:0] w_nxt_cnt;
  logic        w_slot_free;
  logic        w_in_range;
  logic [31:0] w_br_pc;

  assign w_slot_free = !r_if_valid || id_ready;
  assign w_in_range  = (r_pc < PC_LIMIT);
  assign w_br_pc     = br_target & 32'hFFFF_FFFC;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc;
    w_nxt_valid = r_if_valid;
    w_nxt_inst  = r_if_inst;
    w_nxt_if_pc = r_if_pc;
    w_nxt_cnt   = r_fetch_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) w_nxt_state = S_RUN;
      end
      S_RUN: begin
        // Redirect wins over everything, including a stalled word in the slot.
        if (br_taken) begin
          w_nxt_pc    = w_br_pc;
          w_nxt_valid = 1'b0;
        end else if (w_slot_free) begin
          if (!w_in_range) begin
            w_nxt_state = S_DONE;
            w_nxt_valid = 1'b0;
          end else begin
            w_nxt_inst  = mem_inst;
            w_nxt_if_pc = r_pc;
            w_nxt_valid = 1'b1;
            w_nxt_pc    = r_pc + 32'd4;
            w_nxt_cnt   = (r_fetch_cnt == 16'hFFFF) ? r_fetch_cnt : r_fetch_cnt + 16'd1;
          end
        end
      end
      S_DONE: begin
        w_nxt_valid = 1'b0;
        if (start) begin
          w_nxt_state = S_RUN;
          w_nxt_pc    = RESET_PC;
          w_nxt_cnt   = 16'd0;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_if_inst   <= 32'd0;
      r_if_pc     <= 32'd0;
      r_fetch_cnt <= 16'd0;
    end else begin
      r_state     <= w_nxt_state;
      r_pc        <= w_nxt_pc;
      r_if_valid  <= w_nxt_valid;
      r_if_inst   <= w_nxt_inst;
      r_if_pc     <= w_nxt_if_pc;
      r_fetch_cnt <= w_nxt_cnt;
    end
  end

  assign mem_addr  = r_pc;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed scenarios then random traffic
// against a cycle-level reference model of the fetch rules.
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst, start, br_taken, id_ready;
  logic [31:0] br_target;
  logic [31:0] mem_addr, mem_inst;
  logic        if_valid, busy, done;
  logic [31:0] if_inst, if_pc;
  logic [15:0] fetch_cnt;

  always #5 clk = ~clk;

  assign mem_inst = 32'hA000_0000 + {27'd0, mem_addr[6:2]};

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .br_taken(br_taken),
    .br_target(br_target), .id_ready(id_ready), .mem_addr(mem_addr),
    .mem_inst(mem_inst), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .busy(busy), .done(done), .fetch_cnt(fetch_cnt)
  );

  typedef struct {
    bit          valid;
    bit          chk_data;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] addr;
    bit          busy;
    bit          done;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 running, 2 finished
  int          m_mode = 0;
  longint      m_pc = 0;
  bit          m_valid = 0;
  logic [31:0] m_inst = 0;
  logic [31:0] m_ipc = 0;
  int          m_cnt = 0;

  function automatic logic [31:0] rom_word(longint byte_addr);
    return 32'hA000_0000 + 32'(byte_addr / 4);
  endfunction

  task automatic cycle(input bit r, input bit s, input bit b, input int tgt, input bit rdy);
    exp_t e;
    bit   was_reset;
    rst = r; start = s; br_taken = b; br_target = 32'(tgt); id_ready = rdy;
    was_reset = 0;
    if (r) begin
      m_mode = 0; m_pc = 0; m_valid = 0; m_inst = 0; m_ipc = 0; m_cnt = 0;
      was_reset = 1;
    end else if (m_mode == 0) begin
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      if (b) begin
        m_pc = longint'(tgt) - (longint'(tgt) % 4);
        m_valid = 0;
      end else if (!m_valid || rdy) begin
        if (m_pc >= MW * 4) begin
          m_mode = 2;
          m_valid = 0;
        end else begin
          m_inst = rom_word(m_pc);
          m_ipc = 32'(m_pc);
          m_valid = 1;
          m_pc = m_pc + 4;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
      end
    end else begin
      m_valid = 0;
      if (s) begin
        m_mode = 1; m_pc = 0; m_cnt = 0;
      end
    end
    e.valid = m_valid;
    e.chk_data = m_valid || was_reset;
    e.inst = m_inst;
    e.ipc = m_ipc;
    e.addr = 32'(m_pc);
    e.busy = (m_mode == 1);
    e.done = (m_mode == 2);
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("done", {31'd0, done}, {31'd0, e.done});
        chk("mem_addr", mem_addr, e.addr);
        chk("fetch_cnt", {16'd0, fetch_cnt}, 32'(e.cnt));
        if (e.chk_data) begin
          chk("if_inst", if_inst, e.inst);
          chk("if_pc", if_pc, e.ipc);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    rst = 1; start = 0; br_taken = 0; br_target = 0; id_ready = 0;
    // Scenario 1: straight run to DONE
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 8, 1);
    cycle(0, 1, 0, 0, 1);
    repeat (11) cycle(0, 0, 0, 0, 1);
    // Scenario 2: restart, stall on the third word
    cycle(0, 1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 1);
    // Scenario 3: redirect with unaligned target
    cycle(0, 0, 1, 32'h7, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    // Scenario 4: redirect during stall
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h14, 0);
    repeat (3) cycle(0, 0, 0, 0, 1);
    // Scenario 5: out-of-range redirect then restart
    cycle(0, 0, 1, 32'h40, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    // Scenario 6: reset mid-run, start needed to resume
    cycle(0, 0, 1, 32'h0, 1);
    repeat (5) cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h8, 1);
    repeat (2) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) == 0), int'($urandom_range(0, 63)),
            ($urandom_range(0, 3) != 0));
    end
    cycle(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences the single-cycle instruction ROM: owns the PC, drives the ROM byte address and captures the returned word into an IF/ID output register.
- Presents the word to decode with a valid/ready handshake, accepts branch/jump redirects from execute, and stops cleanly when the PC leaves the populated ROM range.
- Sits between the instruction ROM (combinational read, word index = addr[6:2]) and the decode stage of the MIPS-subset CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and on restart.
- MEM_WORDS, 32, number of ROM words; a PC >= MEM_WORDS*4 is out of range.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin or restart fetching from RESET_PC
- br_taken  input  1  redirect request from execute
- br_target  input  32  redirect byte address; bits [1:0] ignored
- id_ready  input  1  decode accepts if_inst this cycle
- mem_addr  output  32  byte address to instruction ROM (= pc, combinational)
- mem_inst  input  32  ROM read data for mem_addr, same cycle
- if_valid  output  1  if_inst/if_pc hold a valid instruction
- if_inst  output  32  fetched instruction
- if_pc  output  32  address of if_inst
- busy  output  1  state == RUN
- done  output  1  state == DONE
- fetch_cnt  output  16  instructions fetched since reset/start, saturating

Behaviour:
- Reset (rst=1 at clock edge, overrides everything): state=IDLE, pc=RESET_PC, if_valid=0, if_inst=0, if_pc=0, fetch_cnt=0. Hence busy=0, done=0, mem_addr=RESET_PC.
- States:
  - IDLE: start -> RUN; all other inputs ignored.
  - RUN: see rules below.
  - DONE: start -> RUN with pc<=RESET_PC, if_valid<=0, fetch_cnt<=0; otherwise stays.
- RUN, evaluated in priority order each cycle:
  1. br_taken=1: pc<={br_target[31:2],2'b00}; if_valid<=0 (flush, even if id_ready=0); no fetch, no count.
  2. slot_free = !if_valid || id_ready. When slot_free and pc >= MEM_WORDS*4: go to DONE; if_valid<=0; pc holds.
  3. When slot_free and pc is in range: if_inst<=mem_inst; if_pc<=pc; if_valid<=1; pc<=pc+4; fetch_cnt<=fetch_cnt+1, saturating at 16'hFFFF.
  4. When if_valid && !id_ready: stall. pc, if_inst, if_pc and if_valid are all held unchanged.
- start while in RUN is ignored.
- br_taken in IDLE or DONE is ignored.
- A redirect to an out-of-range target: one flush cycle, then DONE on the next cycle.
- In DONE, if_valid=0; no further ROM reads are consumed.
- Latency:
  - start sampled at edge t -> RUN at t+1.
  - First if_valid=1 at t+2, with if_inst = ROM[RESET_PC].
  - Steady state: one instruction per cycle while id_ready=1.
- Handshake: a transfer occurs on any edge with if_valid && id_ready. if_inst and if_pc are stable while if_valid && !id_ready.
- Redirect penalty: one bubble. The redirect edge clears if_valid; the target instruction is valid on the following edge.
- pc arithmetic is 32-bit unsigned; +4 wraps mod 2^32, but the range check always terminates before wrap.
- Reset mid-operation: rst=1 in any state returns to full reset values on that edge; any in-flight if_inst is discarded.

Test Plan:
- Bench ROM model: mem[k] = 32'hA000_0000 + k, MEM_WORDS=8.
- Scenario 1, straight run: rst, then start pulse, id_ready=1 held -> if_valid rises 2 cycles after start. if_inst sequence A0000000..A0000007 with if_pc 0,4,...,28 on consecutive cycles. DONE the cycle after the last transfer. fetch_cnt=8, done=1.
- Scenario 2, stall: id_ready=0 for 3 cycles while if_inst=A0000002 -> if_inst/if_pc/mem_addr (=0x0C) frozen. After release, A0000003 appears the next cycle; no instruction is lost or duplicated.
- Scenario 3, redirect: br_taken=1, br_target=32'h0000_0007 while if_valid=1 -> next edge if_valid=0, pc=4. Following edge: if_inst=A0000001, if_pc=4.
- Scenario 4, redirect during stall: id_ready=0 and br_taken=1, target 0x14 -> flush occurs; the next valid instruction is A0000005.
- Scenario 5, out-of-range target 0x40 -> one bubble, then done=1, busy=0, if_valid=0. A subsequent start restarts at A0000000 with fetch_cnt reset.
- Scenario 6, rst mid-run at if_pc=0x10 -> next cycle all outputs at reset values, state IDLE. start is then required to resume.
